// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha1_pkg;

   localparam int unsigned SHA1_BLOCK_WORDS = 16;
   localparam logic [7:0]  SHA1_PAD_MARKER  = 8'h80;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFin
   } pad_state_e;

   typedef enum logic [2:0] {
      KindData,
      KindPartial,
      KindMarker,
      KindZero,
      KindLenHi,
      KindLenLo
   } word_kind_e;

   // Reverse byte order of a 32-bit word (little-endian memory to big-endian stream).
   function automatic logic [31:0] byte_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Keep the top `keep` bytes of w, place the marker right after them, zero the rest.
   function automatic logic [31:0] pad_partial(input logic [31:0] w, input logic [1:0] keep);
      logic [31:0] r;
      case (keep)
         2'd1:    r = {w[31:24], SHA1_PAD_MARKER, 16'h0000};
         2'd2:    r = {w[31:16], SHA1_PAD_MARKER, 8'h00};
         2'd3:    r = {w[31:8], SHA1_PAD_MARKER};
         default: r = {SHA1_PAD_MARKER, 24'h000000};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sha1_pad_fifo.sv
// Small synchronous FIFO holding padded words plus their block/message-last flags.
module sha1_pad_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 34
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           push_i,
   input  logic [Width-1:0]               wdata_i,
   input  logic                           pop_i,
   output logic [Width-1:0]               rdata_o,
   output logic                           empty_o,
   output logic [$clog2(Depth+1)-1:0]     count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign do_push = push_i && (count_q != CntW'(Depth));
   assign do_pop  = pop_i && (count_q != '0);

   // Storage array; written only on an accepted push.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointer and occupancy bookkeeping with wrap at Depth-1.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: reads message bytes from the DPSRAM read port, appends the 0x80 marker,
// zero fill and 64-bit bit length, and streams 16 big-endian words per block.
// Optional build macro SHA1_PAD_BYTE_SWAP_EN: memory words are little-endian and are byte-reversed
// before masking (padding and length words are never swapped).
module sha1_msg_padder
   import sha1_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       message_addr,
   input  logic [31:0]       message_size,
   output logic              busy,
   output logic              done,
   output logic              port_A_clk,
   output logic [ADDR_W-1:0] port_A_addr,
   output logic              port_A_we,
   output logic [31:0]       port_A_data_in,
   input  logic [31:0]       port_A_data_out,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [31:0]       w_data,
   output logic              w_blk_last,
   output logic              w_msg_last
);

   localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

   pad_state_e        state_q;
   logic              busy_q, done_q;
   logic [31:0]       g_q, size_q;
   logic [ADDR_W-1:0] base_q;

   // Current generator slot; in IDLE the start cycle already issues word 0 from the inputs.
   logic              idle_start;
   logic [31:0]       cur_size, cur_g, cur_o, nblk, total;
   logic [ADDR_W-1:0] cur_base;
   word_kind_e        kind;
   logic [31:0]       pre_word;
   logic [1:0]        keep;
   logic              is_read, gen_req, gen_ok, gen_fire;
   logic [31:0]       occupancy;

   // One-cycle read pipeline stage: every slot passes through it so ordering is trivial.
   logic              pend_valid_q;
   word_kind_e        pend_kind_q;
   logic [1:0]        pend_keep_q;
   logic [31:0]       pend_word_q;
   logic              pend_blk_last_q, pend_msg_last_q;

   logic [31:0]       rd_word, push_word;
   logic [33:0]       fifo_rdata;
   logic              fifo_empty, pop;
   logic [CntW-1:0]   fifo_count;

   logic              unused_addr_bits;
   assign unused_addr_bits = ^message_addr[31:ADDR_W];

   assign idle_start = (state_q == StIdle) && start;
   assign cur_size   = (state_q == StIdle) ? message_size : size_q;
   assign cur_base   = (state_q == StIdle) ? message_addr[ADDR_W-1:0] : base_q;
   assign cur_g      = (state_q == StIdle) ? 32'd0 : g_q;
   assign cur_o      = cur_g << 2;
   assign nblk       = 32'(({1'b0, cur_size} + 33'd8) >> 6) + 32'd1;
   assign total      = nblk << 4;

   // Classify the current word and precompute everything that does not need memory data.
   always_comb begin
      kind     = KindZero;
      pre_word = 32'h0;
      if (cur_g == total - 32'd1) begin
         kind     = KindLenLo;
         pre_word = {cur_size[28:0], 3'b000};
      end else if (cur_g == total - 32'd2) begin
         kind     = KindLenHi;
         pre_word = {29'b0, cur_size[31:29]};
      end else if (({1'b0, cur_o} + 33'd4) <= {1'b0, cur_size}) begin
         kind = KindData;
      end else if (cur_o < cur_size) begin
         kind = KindPartial;
      end else if (cur_o == cur_size) begin
         kind     = KindMarker;
         pre_word = {SHA1_PAD_MARKER, 24'h000000};
      end
   end

   assign keep    = 2'(cur_size - cur_o);
   assign is_read = (kind == KindData) || (kind == KindPartial);
   assign gen_req = idle_start || ((state_q == StRun) && (g_q < total));

   // Words already buffered plus the one in the read stage, minus the one leaving this cycle.
   assign pop       = w_valid && w_ready;
   assign occupancy = 32'(fifo_count) + {31'b0, pend_valid_q} - {31'b0, pop};
   assign gen_ok    = occupancy < BUF_DEPTH;
   assign gen_fire  = gen_req && gen_ok && !reset;

   assign port_A_clk     = clk;
   assign port_A_we      = 1'b0;
   assign port_A_data_in = 32'h0;
   assign port_A_addr    = (gen_fire && is_read) ? (cur_base + cur_o[ADDR_W-1:0]) : '0;

   // Read stage: remember how to finish the word when its memory data returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q    <= 1'b0;
         pend_kind_q     <= KindZero;
         pend_keep_q     <= 2'd0;
         pend_word_q     <= 32'h0;
         pend_blk_last_q <= 1'b0;
         pend_msg_last_q <= 1'b0;
      end else begin
         pend_valid_q <= gen_fire;
         if (gen_fire) begin
            pend_kind_q     <= kind;
            pend_keep_q     <= keep;
            pend_word_q     <= pre_word;
            pend_blk_last_q <= (cur_g[3:0] == 4'(SHA1_BLOCK_WORDS - 1));
            pend_msg_last_q <= (cur_g == total - 32'd1);
         end
      end
   end

`ifdef SHA1_PAD_BYTE_SWAP_EN
   assign rd_word = byte_swap32(port_A_data_out);
`else
   assign rd_word = port_A_data_out;
`endif

   // Finish the word from returning memory data or the precomputed padding value.
   always_comb begin
      push_word = pend_word_q;
      case (pend_kind_q)
         KindData:    push_word = rd_word;
         KindPartial: push_word = pad_partial(rd_word, pend_keep_q);
         default:     push_word = pend_word_q;
      endcase
   end

   sha1_pad_fifo #(
      .Depth (BUF_DEPTH),
      .Width (34)
   ) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (pend_valid_q),
      .wdata_i ({push_word, pend_blk_last_q, pend_msg_last_q}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign w_valid    = !fifo_empty;
   assign w_data     = fifo_rdata[33:2];
   assign w_blk_last = fifo_rdata[1];
   assign w_msg_last = fifo_rdata[0];

   // Control FSM with slot counter and registered busy/done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         g_q     <= 32'd0;
         size_q  <= 32'd0;
         base_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
                  size_q  <= message_size;
                  base_q  <= message_addr[ADDR_W-1:0];
                  g_q     <= gen_fire ? 32'd1 : 32'd0;
               end
            end
            StRun: begin
               if (gen_fire) begin
                  g_q <= g_q + 32'd1;
               end
               if (pop && w_msg_last) begin
                  state_q <= StFin;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            StFin: begin
               done_q  <= 1'b0;
               g_q     <= 32'd0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Self-checking bench for sha1_msg_padder: table of messages plus a mid-message reset sequence,
// with a byte-level reference model feeding a scoreboard queue.
module tb_sha1_msg_padder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] message_addr = 32'h0;
   logic [31:0] message_size = 32'h0;
   logic        busy, done, port_A_clk, port_A_we;
   logic [15:0] port_A_addr;
   logic [31:0] port_A_data_in;
   logic [31:0] port_A_data_out = 32'h0;
   logic        w_valid;
   logic        w_ready = 1'b1;
   logic [31:0] w_data;
   logic        w_blk_last, w_msg_last;

   typedef struct {
      logic [31:0] data;
      logic        blk_last;
      logic        msg_last;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] len;
      bit          rnd;
      int          nwords;
      int          spot_idx;
      logic [31:0] spot_val;
   } vec_t;

   exp_t        sb[$];
   logic [31:0] mem [16384];
   logic [31:0] got [64];
   int          vectors = 0;
   int          miscompares = 0;
   int          acc_idx = 0;
   int          done_cnt = 0;
   bit          expect_done = 0;
   bit          rand_ready = 0;
   vec_t        tests [9];

   sha1_msg_padder #(
      .ADDR_W    (16),
      .BUF_DEPTH (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .message_addr    (message_addr),
      .message_size    (message_size),
      .busy            (busy),
      .done            (done),
      .port_A_clk      (port_A_clk),
      .port_A_addr     (port_A_addr),
      .port_A_we       (port_A_we),
      .port_A_data_in  (port_A_data_in),
      .port_A_data_out (port_A_data_out),
      .w_valid         (w_valid),
      .w_ready         (w_ready),
      .w_data          (w_data),
      .w_blk_last      (w_blk_last),
      .w_msg_last      (w_msg_last)
   );

   initial forever #5 clk = ~clk;

   // Synchronous-read memory model with one cycle of latency.
   always @(posedge clk) port_A_data_out <= mem[port_A_addr[15:2]];

   // Ready driver: either constant 1 or a 50% coin flip each cycle.
   initial forever begin
      @(posedge clk);
      #1;
      w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Message byte b of a message starting at base, as the core should see it.
   function automatic logic [7:0] msg_byte(input logic [15:0] base, input longint unsigned b);
      logic [15:0] a;
      logic [31:0] w;
      int          lane;
      a    = base + 16'(b);
      w    = mem[a[15:2]];
      lane = int'(b % 4);
`ifdef SHA1_PAD_BYTE_SWAP_EN
      return w[8*lane +: 8];
`else
      return w[8*(3-lane) +: 8];
`endif
   endfunction

   function automatic longint unsigned total_words(input logic [31:0] len);
      return 16 * ((longint'(len) + 8) / 64 + 1);
   endfunction

   function automatic exp_t exp_word(input logic [15:0] base, input logic [31:0] len,
                                     input longint unsigned g);
      exp_t            e;
      longint unsigned gt;
      longint unsigned b;
      logic [63:0]     bits;
      logic [7:0]      by;
      gt         = total_words(len);
      bits       = {29'b0, len, 3'b000};
      e.blk_last = (g % 16 == 15);
      e.msg_last = (g == gt - 1);
      e.data     = 32'h0;
      if (g == gt - 2) begin
         e.data = bits[63:32];
      end else if (g == gt - 1) begin
         e.data = bits[31:0];
      end else begin
         for (int i = 0; i < 4; i++) begin
            b = 4 * g + longint'(i);
            if (b < longint'(len)) by = msg_byte(base, b);
            else if (b == longint'(len)) by = 8'h80;
            else by = 8'h00;
            e.data = {e.data[23:0], by};
         end
      end
      return e;
   endfunction

   // Monitor: compare every accepted word against the scoreboard and police done.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!reset) begin
         if (expect_done) begin
            check("done_pulse", 32'(done), 32'd1);
            expect_done = 0;
         end else if (done) begin
            check("spurious_done", 32'(done), 32'd0);
         end
         if (done) done_cnt++;
         if (w_valid && w_ready) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL extra_word: got %h, expected no word", w_data);
            end else begin
               e = sb.pop_front();
               check("w_data", w_data, e.data);
               check("w_blk_last", 32'(w_blk_last), 32'(e.blk_last));
               check("w_msg_last", 32'(w_msg_last), 32'(e.msg_last));
               if (e.msg_last) expect_done = 1;
            end
            if (acc_idx < 64) got[acc_idx] = w_data;
            acc_idx++;
         end
      end
   end

   task automatic launch(input logic [31:0] addr, input logic [31:0] len);
      sb.delete();
      acc_idx = 0;
      for (longint unsigned g = 0; g < total_words(len); g++) begin
         sb.push_back(exp_word(addr[15:0], len, g));
      end
      @(posedge clk);
      #1;
      message_addr = addr;
      message_size = len;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_msg(input vec_t v);
      int d0;
      int cycles;
      d0         = done_cnt;
      rand_ready = v.rnd;
      launch(v.addr, v.len);
      @(negedge clk);
      check("busy_after_start", 32'(busy), 32'd1);
      if (!v.rnd) check("w_valid_early", 32'(w_valid), 32'd0);
      @(negedge clk);
      if (!v.rnd && v.len != 0) check("first_valid_latency", 32'(w_valid), 32'd1);
      cycles = 0;
      while ((sb.size() != 0 || done_cnt == d0) && cycles < 3000) begin
         @(negedge clk);
         cycles++;
      end
      if (cycles >= 3000) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: got %0d words left, expected 0", sb.size());
      end
      repeat (3) @(negedge clk);
      check("word_count", 32'(acc_idx), 32'(v.nwords));
      check("spot_word", got[v.spot_idx], v.spot_val);
      check("done_count", 32'(done_cnt - d0), 32'd1);
      check("busy_after_done", 32'(busy), 32'd0);
      check("w_valid_after_done", 32'(w_valid), 32'd0);
      rand_ready = 0;
   endtask

   initial begin
      int   cycles;
      vec_t v3;
      for (int i = 0; i < 16384; i++) mem[i] = $urandom;
`ifdef SHA1_PAD_BYTE_SWAP_EN
      mem[32'h0200 >> 2] = 32'h0063_6261;
`else
      mem[32'h0200 >> 2] = 32'h6162_6300;
`endif
      //          addr            L    rnd  n   idx  value
      tests[0] = '{32'h0000_1000, 0,   0,   16, 0,   32'h8000_0000};
      tests[1] = '{32'h0000_0200, 3,   0,   16, 0,   32'h6162_6380};
      tests[2] = '{32'h0000_2000, 56,  0,   32, 14,  32'h8000_0000};
      tests[3] = '{32'h0000_3000, 64,  0,   32, 16,  32'h8000_0000};
      tests[4] = '{32'h0000_4000, 20,  1,   16, 5,   32'h8000_0000};
      tests[5] = '{32'hABCD_FFF8, 20,  0,   16, 15,  32'h0000_00A0};
      tests[6] = '{32'h0000_5000, 100, 1,   32, 31,  32'h0000_0320};
      tests[7] = '{32'h0000_6000, 55,  0,   16, 15,  32'h0000_01B8};
      tests[8] = '{32'h0000_7000, 63,  0,   32, 31,  32'h0000_01F8};

      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_w_valid", 32'(w_valid), 32'd0);
      check("reset_addr", 32'(port_A_addr), 32'd0);
      check("port_A_we", 32'(port_A_we), 32'd0);
      check("port_A_data_in", port_A_data_in, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int t = 0; t < 9; t++) run_msg(tests[t]);

      // L=56 and L=64 second spot values from the known layout.
      run_msg(tests[2]);
      check("l56_word31", got[31], 32'h0000_01C0);
      run_msg(tests[3]);
      check("l64_word31", got[31], 32'h0000_0200);

      // Abort an L=100 message at word 7, then a clean L=3 message must follow.
      rand_ready = 0;
      launch(32'h0000_0400, 32'd100);
      cycles = 0;
      while (acc_idx < 7 && cycles < 500) begin
         @(negedge clk);
         cycles++;
      end
      if (cycles >= 500) begin
         vectors++;
         miscompares++;
         $display("FAIL abort_wait: got %0d words, expected 7", acc_idx);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_w_valid", 32'(w_valid), 32'd0);
      check("abort_addr", 32'(port_A_addr), 32'd0);
      @(posedge clk);
      #1;
      reset       = 1'b0;
      expect_done = 0;
      sb.delete();
      acc_idx = 0;
      repeat (3) @(negedge clk);
      check("no_stale_word", 32'(w_valid), 32'd0);
      check("no_abort_done", 32'(acc_idx), 32'd0);
      v3 = tests[1];
      run_msg(v3);
      check("post_abort_word15", got[15], 32'h0000_0018);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
